// File: rtl/audio_src_arbiter_if.sv
// Tone-source arbitration bus: song/SFX requests, tempo tick and mute in; divider, grant, ack and source out.
interface audio_src_arbiter_if;
  logic        tick;
  logic        song_req;
  logic [19:0] song_div;
  logic        sfx_req;
  logic [19:0] sfx_div;
  logic [3:0]  sfx_len;
  logic        mute;
  logic [19:0] note_div;
  logic        song_grant;
  logic        sfx_ack;
  logic [1:0]  src;

  modport master (
    output tick, song_req, song_div, sfx_req, sfx_div, sfx_len, mute,
    input  note_div, song_grant, sfx_ack, src
  );

  modport slave (
    input  tick, song_req, song_div, sfx_req, sfx_div, sfx_len, mute,
    output note_div, song_grant, sfx_ack, src
  );
endinterface

// File: rtl/audio_src_arbiter.sv
// Arbitrates the note generator between the song player and sound effects (SFX wins).
// Optional AUDIO_ARB_GAP_EN inserts GAP_TICKS silent ticks on non-idle source changes.
module audio_src_arbiter #(
  parameter logic [19:0] SILENCE_DIV = 20'd0,
  parameter int          GAP_TICKS   = 2
) (
  input  logic               clk,
  input  logic               reset,
  audio_src_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SONG = 2'd1, SFX = 2'd2, GAP = 2'd3} state_t;

  state_t      state;
  logic        sfx_q;
  logic        sfx_edge;
  logic [3:0]  sfx_cnt;
  logic [3:0]  len_eff;
  logic [19:0] sfx_div_q;
  logic [19:0] note_div_q;
  logic        sfx_ack_q;
`ifdef AUDIO_ARB_GAP_EN
  state_t      gap_tgt;
  logic [15:0] gap_cnt;
`endif

  // A held request counts once: only the rising edge is accepted.
  assign sfx_edge = bus.sfx_req & ~sfx_q;
  assign len_eff  = (bus.sfx_len == 4'd0) ? 4'd1 : bus.sfx_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sfx_q      <= 1'b0;
      sfx_cnt    <= 4'd0;
      sfx_div_q  <= 20'd0;
      sfx_ack_q  <= 1'b0;
      note_div_q <= SILENCE_DIV;
`ifdef AUDIO_ARB_GAP_EN
      gap_tgt    <= IDLE;
      gap_cnt    <= 16'd0;
`endif
    end else begin
      sfx_q     <= bus.sfx_req;
      sfx_ack_q <= 1'b0;

      // Divider follows the pre-edge state, giving one clk of latency.
      if (bus.mute)
        note_div_q <= SILENCE_DIV;
      else begin
        case (state)
          SONG:    note_div_q <= bus.song_div;
          SFX:     note_div_q <= sfx_div_q;
          default: note_div_q <= SILENCE_DIV;
        endcase
      end

      // Accept or retrigger: the freshly loaded count ignores a same-clk tick.
      if (sfx_edge) begin
        sfx_div_q <= bus.sfx_div;
        sfx_cnt   <= len_eff;
        sfx_ack_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sfx_edge)          state <= SFX;
          else if (bus.song_req) state <= SONG;
        end

        SONG: begin
          if (sfx_edge) begin
`ifdef AUDIO_ARB_GAP_EN
            state   <= GAP;
            gap_tgt <= SFX;
            gap_cnt <= GAP_TICKS[15:0];
`else
            state   <= SFX;
`endif
          end else if (!bus.song_req) begin
            state <= IDLE;
          end
        end

        SFX: begin
          if (!sfx_edge && bus.tick) begin
            if (sfx_cnt <= 4'd1) begin
              sfx_cnt <= 4'd0;
              if (bus.song_req) begin
`ifdef AUDIO_ARB_GAP_EN
                state   <= GAP;
                gap_tgt <= SONG;
                gap_cnt <= GAP_TICKS[15:0];
`else
                state   <= SONG;
`endif
              end else begin
                state <= IDLE;
              end
            end else begin
              sfx_cnt <= sfx_cnt - 4'd1;
            end
          end
        end

        default: begin
`ifdef AUDIO_ARB_GAP_EN
          // A new SFX retargets the gap but does not restart its count.
          if (sfx_edge) gap_tgt <= SFX;
          if (bus.tick) begin
            if (gap_cnt <= 16'd1) begin
              gap_cnt <= 16'd0;
              if (sfx_edge || gap_tgt == SFX) state <= SFX;
              else if (bus.song_req)          state <= SONG;
              else                            state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt - 16'd1;
            end
          end
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end

  assign bus.note_div   = note_div_q;
  assign bus.sfx_ack    = sfx_ack_q;
  assign bus.song_grant = (state == SONG);
  assign bus.src        = (state == SONG) ? 2'b01 :
                          (state == SFX)  ? 2'b10 : 2'b00;

endmodule
